// File: rtl/conv_pkg.sv
// Shared widths, FSM state type and window geometry for the 3x3 window generator.
package conv_pkg;
    localparam int BIT_W    = 8;
    localparam int PIX_W    = 16;
    localparam int WIN_W    = 144;
    localparam int WIN_ELEM = 18;

    typedef enum logic {S_LOAD, S_RUN} state_t;
endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One row of pixels indexed by column: combinational read, write on the clock edge (read-before-write).
// Latency: read data is the previous write at that index; no backpressure, the caller gates wr_en.
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    idx,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd_data
);
    logic [PIX_W-1:0] mem [DEPTH];

    assign rd_data = mem[idx];

    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= wr_data;
    end
endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 2-channel 3x3 windows; window valid 1 cycle after the completing pixel.
// Pixel input stalls while a window is held unconsumed; CONV_WIN_COORD_EN adds window centre outputs.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [PIX_W-1:0] i_pix,
    input  logic             i_pix_valid,
    output logic             o_pix_ready,
    input  logic             i_sof,
    output logic [WIN_W-1:0] o_win,
    output logic             o_win_valid,
    input  logic             i_win_ready,
    output logic             o_win_last
`ifdef CONV_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_W)-1:0] o_win_x,
    output logic [$clog2(IMG_H)-1:0] o_win_y
`endif
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [XW-1:0]    x_cnt, xe;
    logic [YW-1:0]    y_cnt, ye;
    state_t           state;
    logic             acc, row_end, frame_end, emit;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    // win_q[col][row]; col 2 is the newest column
    logic [2:0][2:0][PIX_W-1:0] win_q;

    assign o_pix_ready = ~o_win_valid | i_win_ready;
    assign acc         = i_pix_valid & o_pix_ready;

    // A start-of-frame pixel overrides the counters and is placed at (0,0)
    assign xe        = i_sof ? '0 : x_cnt;
    assign ye        = i_sof ? '0 : y_cnt;
    assign row_end   = (xe == XW'(IMG_W - 1));
    assign frame_end = row_end && (ye == YW'(IMG_H - 1));
    assign emit      = acc && (state == S_RUN) && (xe >= XW'(2));

    line_buffer #(.DEPTH(IMG_W)) u_lb0 (
        .clk     (i_clk),
        .wr_en   (acc),
        .idx     (xe),
        .wr_data (lb1_rd),
        .rd_data (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk     (i_clk),
        .wr_en   (acc),
        .idx     (xe),
        .wr_data (i_pix),
        .rd_data (lb1_rd)
    );

    always_comb begin
        o_win = '0;
        for (int k = 0; k < WIN_ELEM / 2; k++) begin
            o_win[WIN_W - 1 - BIT_W * k -: BIT_W]       = win_q[k % 3][k / 3][PIX_W - 1 -: BIT_W];
            o_win[WIN_W - 1 - BIT_W * (k + 9) -: BIT_W] = win_q[k % 3][k / 3][BIT_W - 1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            state       <= S_LOAD;
            win_q       <= '0;
            o_win_valid <= 1'b0;
            o_win_last  <= 1'b0;
        end else if (acc) begin
            win_q[0]    <= win_q[1];
            win_q[1]    <= win_q[2];
            win_q[2][0] <= lb0_rd;
            win_q[2][1] <= lb1_rd;
            win_q[2][2] <= i_pix;
            o_win_valid <= emit;
            o_win_last  <= emit && frame_end;
            if (row_end) begin
                x_cnt <= '0;
                y_cnt <= (ye == YW'(IMG_H - 1)) ? '0 : ye + YW'(1);
            end else begin
                x_cnt <= xe + XW'(1);
                y_cnt <= ye;
            end
            case (state)
                S_LOAD: if (row_end && ye == YW'(1)) state <= S_RUN;
                S_RUN:  if (i_sof || frame_end) state <= S_LOAD;
                default: state <= S_LOAD;
            endcase
        end else if (i_win_ready) begin
            o_win_valid <= 1'b0;
            o_win_last  <= 1'b0;
        end
    end

`ifdef CONV_WIN_COORD_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_win_x <= '0;
            o_win_y <= '0;
        end else if (emit) begin
            o_win_x <= xe - XW'(1);
            o_win_y <= ye - YW'(1);
        end
    end
`endif
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen at 4x4: scenario tasks against a frame-array window model.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  pix;
    logic         pix_valid;
    logic         pix_ready;
    logic         sof;
    logic [143:0] win;
    logic         win_valid;
    logic         win_ready;
    logic         win_last;
`ifdef CONV_WIN_COORD_EN
    logic [1:0]   win_x, win_y;
`endif

    always #5 clk = ~clk;

    conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pix       (pix),
        .i_pix_valid (pix_valid),
        .o_pix_ready (pix_ready),
        .i_sof       (sof),
        .o_win       (win),
        .o_win_valid (win_valid),
        .i_win_ready (win_ready),
        .o_win_last  (win_last)
`ifdef CONV_WIN_COORD_EN
        ,
        .o_win_x     (win_x),
        .o_win_y     (win_y)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the frame as a 2D image, position from a pixel count.
    logic [15:0]  img [H][W];
    int           mx, my, acc_cnt;
    logic [143:0] exp_win[$];
    logic         exp_last[$];
    int           exp_idx[$], exp_x[$], exp_y[$];
    logic [143:0] got_win[$];
    logic         got_last[$];
    int           got_idx[$], got_x[$], got_y[$];
    logic [15:0]  src_pix[$];
    bit           src_sof[$];

    function automatic logic [143:0] make_win(input int cx, input int cy);
        logic [143:0] w;
        int k;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                k = r * 3 + c;
                w[143 - 8 * k -: 8]       = img[cy - 1 + r][cx - 1 + c][15:8];
                w[143 - 8 * (k + 9) -: 8] = img[cy - 1 + r][cx - 1 + c][7:0];
            end
        end
        return w;
    endfunction

    task automatic model_clear();
        mx = 0; my = 0; acc_cnt = 0;
        exp_win.delete(); exp_last.delete(); exp_idx.delete(); exp_x.delete(); exp_y.delete();
        got_win.delete(); got_last.delete(); got_idx.delete(); got_x.delete(); got_y.delete();
    endtask

    task automatic model_accept(input logic [15:0] p, input bit s);
        if (s) begin mx = 0; my = 0; end
        img[my][mx] = p;
        acc_cnt++;
        if (mx >= 2 && my >= 2) begin
            exp_win.push_back(make_win(mx - 1, my - 1));
            exp_last.push_back(mx == W - 1 && my == H - 1);
            exp_idx.push_back(acc_cnt);
            exp_x.push_back(mx - 1);
            exp_y.push_back(my - 1);
        end
        mx++;
        if (mx == W) begin mx = 0; my = (my + 1) % H; end
    endtask

    // One clock: drive at #1 after the edge, sample at the falling edge.
    task automatic cycle(input logic pv, input logic [15:0] p, input logic s, input logic wr,
                         output logic acc, output logic [143:0] s_win, output logic s_rdy);
        pix_valid = pv; pix = p; sof = s; win_ready = wr;
        @(negedge clk);
        acc   = pv && pix_ready;
        s_win = win;
        s_rdy = pix_ready;
        if (win_valid && wr) begin
            got_win.push_back(win);
            got_last.push_back(win_last);
            got_idx.push_back(acc_cnt);
`ifdef CONV_WIN_COORD_EN
            got_x.push_back(int'(win_x));
            got_y.push_back(int'(win_y));
`endif
        end
        if (acc) model_accept(p, s);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pix_valid = 1'b0; pix = '0; sof = 1'b0; win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic src_pattern(input int n, input int base);
        logic [7:0] b;
        src_pix.delete(); src_sof.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'((i % 16) + base);
            src_pix.push_back({b, b + 8'h80});
            src_sof.push_back(1'b0);
        end
    endtask

    task automatic run_stream(input string name, input int n, input bit rnd_v, input bit rnd_r);
        int i, cyc;
        logic pv, wr, acc, rdy;
        logic [143:0] sw;
        i = 0; cyc = 0;
        while (i < n && cyc < 2000) begin
            pv = rnd_v ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr = rnd_r ? ($urandom_range(0, 2) != 0) : 1'b1;
            cycle(pv, src_pix[i], pv ? src_sof[i] : 1'($urandom_range(0, 1)), wr, acc, sw, rdy);
            if (acc) i++;
            cyc++;
        end
        for (int d = 0; d < 4; d++) cycle(1'b0, '0, 1'b0, 1'b1, acc, sw, rdy);
        tests++;
        if (i != n) begin
            fails++;
            $display("FAIL %s stream_timeout accepted %0d required %0d", name, i, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (win !== '0)       begin fails++; $display("FAIL reset o_win got %h exp 0", win); end
        tests++; if (win_valid !== 0)  begin fails++; $display("FAIL reset o_win_valid got %b exp 0", win_valid); end
        tests++; if (win_last !== 0)   begin fails++; $display("FAIL reset o_win_last got %b exp 0", win_last); end
        tests++; if (pix_ready !== 1)  begin fails++; $display("FAIL reset o_pix_ready got %b exp 1", pix_ready); end
    endtask

    task automatic test_basic();
        int eidx [4] = '{11, 12, 15, 16};
        logic [143:0] w0;
        do_reset();
        src_pattern(16, 0);
        run_stream("basic", 16, 1'b0, 1'b0);
        tests++;
        if (got_win.size() != 4) begin fails++; $display("FAIL basic win_count got %0d exp 4", got_win.size()); end
        for (int i = 0; i < got_win.size() && i < 4; i++) begin
            tests++; if (got_win[i] !== exp_win[i]) begin fails++; $display("FAIL basic win%0d got %h exp %h", i, got_win[i], exp_win[i]); end
            tests++; if (got_idx[i] !== eidx[i])    begin fails++; $display("FAIL basic pos%0d got %0d exp %0d", i, got_idx[i], eidx[i]); end
            tests++; if (got_last[i] !== (i == 3))  begin fails++; $display("FAIL basic last%0d got %b exp %b", i, got_last[i], i == 3); end
`ifdef CONV_WIN_COORD_EN
            tests++;
            if (got_x[i] != 1 + i % 2 || got_y[i] != 1 + i / 2) begin
                fails++; $display("FAIL basic coord%0d got (%0d,%0d) exp (%0d,%0d)", i, got_x[i], got_y[i], 1 + i % 2, 1 + i / 2);
            end
`endif
        end
        if (got_win.size() > 0) begin
            w0 = got_win[0];
            tests++;
            if (w0[143:136] !== 8'h00 || w0[79:72] !== 8'h0A || w0[71:64] !== 8'h80 || w0[7:0] !== 8'h8A) begin
                fails++; $display("FAIL basic first_fields got %h %h %h %h exp 00 0a 80 8a", w0[143:136], w0[79:72], w0[71:64], w0[7:0]);
            end
        end
    endtask

    task automatic test_stall();
        int i, cyc, stall;
        bit done;
        logic acc, rdy;
        logic [143:0] sw, snap;
        do_reset();
        src_pattern(16, 0);
        i = 0; cyc = 0; stall = 0; done = 0; snap = '0;
        while (i < 16 && cyc < 200) begin
            if (!done && win_valid) begin stall = 3; done = 1; snap = win; end
            cycle(1'b1, src_pix[i], 1'b0, stall == 0, acc, sw, rdy);
            if (stall > 0) begin
                tests++; if (sw !== snap)  begin fails++; $display("FAIL stall hold got %h exp %h", sw, snap); end
                tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL stall pix_ready got %b exp 0", rdy); end
                tests++; if (acc !== 1'b0) begin fails++; $display("FAIL stall accepted pixel %0d got 1 exp 0", i); end
                stall--;
            end
            if (acc) i++;
            cyc++;
        end
        for (int d = 0; d < 4; d++) cycle(1'b0, '0, 1'b0, 1'b1, acc, sw, rdy);
        tests++;
        if (got_win.size() != 4 || exp_win.size() != 4) begin
            fails++; $display("FAIL stall win_count got %0d exp 4", got_win.size());
        end
        for (int k = 0; k < got_win.size() && k < exp_win.size(); k++) begin
            tests++; if (got_win[k] !== exp_win[k]) begin fails++; $display("FAIL stall win%0d got %h exp %h", k, got_win[k], exp_win[k]); end
            tests++; if (got_last[k] !== exp_last[k]) begin fails++; $display("FAIL stall last%0d got %b exp %b", k, got_last[k], exp_last[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [143:0] w4;
        do_reset();
        src_pattern(32, 0);
        run_stream("b2b", 32, 1'b1, 1'b1);
        tests++;
        if (got_win.size() != 8) begin fails++; $display("FAIL b2b win_count got %0d exp 8", got_win.size()); end
        for (int i = 0; i < got_win.size() && i < exp_win.size(); i++) begin
            tests++; if (got_win[i] !== exp_win[i])   begin fails++; $display("FAIL b2b win%0d got %h exp %h", i, got_win[i], exp_win[i]); end
            tests++; if (got_last[i] !== exp_last[i]) begin fails++; $display("FAIL b2b last%0d got %b exp %b", i, got_last[i], exp_last[i]); end
            tests++; if (got_idx[i] !== exp_idx[i])   begin fails++; $display("FAIL b2b pos%0d got %0d exp %0d", i, got_idx[i], exp_idx[i]); end
        end
        if (got_win.size() > 4) begin
            w4 = got_win[4];
            tests++; if (w4[143:136] !== 8'h00) begin fails++; $display("FAIL b2b frame2_elem0 got %h exp 00", w4[143:136]); end
        end
    endtask

    task automatic test_sof();
        logic [15:0] p;
        do_reset();
        src_pattern(6, 0);
        for (int i = 0; i < 16; i++) begin
            p = {8'(8'h20 + i), 8'(8'hA0 + i)};
            src_pix.push_back(p);
            src_sof.push_back(i == 0);
        end
        run_stream("sof", 22, 1'b0, 1'b0);
        tests++;
        if (got_win.size() != 4) begin fails++; $display("FAIL sof win_count got %0d exp 4", got_win.size()); end
        if (got_idx.size() > 0) begin
            tests++; if (got_idx[0] != 17) begin fails++; $display("FAIL sof first_pos got %0d exp 17", got_idx[0]); end
        end
        for (int i = 0; i < got_win.size() && i < exp_win.size(); i++) begin
            tests++; if (got_win[i] !== exp_win[i])   begin fails++; $display("FAIL sof win%0d got %h exp %h", i, got_win[i], exp_win[i]); end
            tests++; if (got_last[i] !== exp_last[i]) begin fails++; $display("FAIL sof last%0d got %b exp %b", i, got_last[i], exp_last[i]); end
        end
    endtask

    task automatic test_random();
        do_reset();
        src_pix.delete(); src_sof.delete();
        for (int i = 0; i < 48; i++) begin
            src_pix.push_back(16'($urandom));
            src_sof.push_back(1'b0);
        end
        run_stream("random", 48, 1'b1, 1'b1);
        tests++;
        if (got_win.size() != 12) begin fails++; $display("FAIL random win_count got %0d exp 12", got_win.size()); end
        for (int i = 0; i < got_win.size() && i < exp_win.size(); i++) begin
            tests++; if (got_win[i] !== exp_win[i])   begin fails++; $display("FAIL random win%0d got %h exp %h", i, got_win[i], exp_win[i]); end
            tests++; if (got_last[i] !== exp_last[i]) begin fails++; $display("FAIL random last%0d got %b exp %b", i, got_last[i], exp_last[i]); end
`ifdef CONV_WIN_COORD_EN
            tests++;
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                fails++; $display("FAIL random coord%0d got (%0d,%0d) exp (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        int i, cyc;
        logic acc, rdy;
        logic [143:0] sw;
        do_reset();
        src_pattern(16, 0);
        i = 0; cyc = 0;
        while (!win_valid && i < 16 && cyc < 100) begin
            cycle(1'b1, src_pix[i], 1'b0, 1'b0, acc, sw, rdy);
            if (acc) i++;
            cyc++;
        end
        tests++; if (win_valid !== 1'b1) begin fails++; $display("FAIL rstmid pending_window got %b exp 1", win_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (win !== '0)       begin fails++; $display("FAIL rstmid o_win got %h exp 0", win); end
        tests++; if (win_valid !== 0)  begin fails++; $display("FAIL rstmid o_win_valid got %b exp 0", win_valid); end
        tests++; if (win_last !== 0)   begin fails++; $display("FAIL rstmid o_win_last got %b exp 0", win_last); end
        tests++; if (pix_ready !== 1)  begin fails++; $display("FAIL rstmid o_pix_ready got %b exp 1", pix_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        src_pattern(16, 3);
        run_stream("rstmid", 16, 1'b0, 1'b0);
        tests++;
        if (got_win.size() != 4) begin fails++; $display("FAIL rstmid win_count got %0d exp 4", got_win.size()); end
        for (int k = 0; k < got_win.size() && k < exp_win.size(); k++) begin
            tests++; if (got_win[k] !== exp_win[k]) begin fails++; $display("FAIL rstmid win%0d got %h exp %h", k, got_win[k], exp_win[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_sof();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
